// File: rtl/mips_issue_ctrl.sv
// mips_issue_ctrl: round-robin issue of req0/req1 into a fixed-latency pipe (pipe_*), RAW hazard stall, in-order tagged responses (rsp_*), stall_cnt and sticky err_orphan
module mips_issue_ctrl #(
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  input  logic        req1_valid,
  input  logic [31:0] req0_instr,
  input  logic [31:0] req1_instr,
  input  logic [14:0] req0_oreg,
  input  logic [14:0] req1_oreg,
  output logic        req0_ready,
  output logic        req1_ready,
  input  logic        hold,
  output logic        pipe_in_valid,
  output logic [31:0] pipe_instruction,
  output logic [14:0] pipe_output_reg,
  input  logic        pipe_out_valid,
  input  logic        pipe_fail,
  input  logic [31:0] pipe_out_1,
  input  logic [31:0] pipe_out_2,
  input  logic [31:0] pipe_out_3,
  output logic        rsp_valid,
  output logic        rsp_id,
  output logic        rsp_fail,
  output logic [31:0] rsp_out_1,
  output logic [31:0] rsp_out_2,
  output logic [31:0] rsp_out_3,
  output logic [15:0] stall_cnt,
  output logic        err_orphan
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  logic          ptr, win, active, hz, grant, stall, pop, has_dst;
  logic [4:0]    dst, rs, rt;
  logic          fifo [FIFO_DEPTH];
  logic [AW-1:0] wp, rp;
  logic [CW-1:0] cnt;
  assign win     = (req0_valid && req1_valid) ? ptr : req1_valid;
  assign rs      = win ? req1_instr[25:21] : req0_instr[25:21];
  assign rt      = win ? req1_instr[20:16] : req0_instr[20:16];
  assign has_dst = pipe_instruction[31:26] == 6'd0 || pipe_instruction[31:26] == 6'd8;
  assign dst     = pipe_instruction[31:26] == 6'd0 ? pipe_instruction[15:11] : pipe_instruction[20:16];
  // only the round-robin winner is checked; a blocked winner blocks the whole cycle
  assign hz      = pipe_in_valid && has_dst && (rs == dst || rt == dst);
  assign active  = rst_n && !hold && (req0_valid || req1_valid);
  assign grant   = active && !hz;
  assign stall   = active && hz;
  assign req0_ready = grant && !win;
  assign req1_ready = grant && win;
  assign pop     = pipe_out_valid && cnt != '0;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr              <= 1'b0;
      pipe_in_valid    <= 1'b0;
      pipe_instruction <= '0;
      pipe_output_reg  <= '0;
      rsp_valid        <= 1'b0;
      rsp_id           <= 1'b0;
      rsp_fail         <= 1'b0;
      rsp_out_1        <= '0;
      rsp_out_2        <= '0;
      rsp_out_3        <= '0;
      stall_cnt        <= '0;
      err_orphan       <= 1'b0;
      wp               <= '0;
      rp               <= '0;
      cnt              <= '0;
    end else begin
      pipe_in_valid <= grant;
      if (grant) begin
        pipe_instruction <= win ? req1_instr : req0_instr;
        pipe_output_reg  <= win ? req1_oreg : req0_oreg;
        ptr              <= ~win;
        fifo[wp]         <= win;
        wp               <= wp + 1'b1;
      end
      rsp_valid <= pop;
      if (pop) begin
        rsp_id    <= fifo[rp];
        rsp_fail  <= pipe_fail;
        rsp_out_1 <= pipe_out_1;
        rsp_out_2 <= pipe_out_2;
        rsp_out_3 <= pipe_out_3;
        rp        <= rp + 1'b1;
      end
      cnt <= cnt + CW'(grant) - CW'(pop);
      if (pipe_out_valid && cnt == '0) err_orphan <= 1'b1;
      if (stall && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
    end
  end
endmodule

// File: doc/mips_issue_ctrl.md
MIPS_ISSUE_CTRL -- requirements
Module: mips_issue_ctrl

Interface
REQ-001 Parameter: FIFO_DEPTH, default 8, tag-FIFO entries; SHALL be a power of 2 and at least 6.
REQ-002 Ports SHALL be as follows.
- clk  in  1  sole clock; all state on rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- req0_valid, req1_valid  in  1  requester N presents an instruction.
- req0_instr, req1_instr  in  32  instruction word.
- req0_oreg, req1_oreg  in  15  three 5-bit output register selects.
- req0_ready, req1_ready  out  1  grant; a transfer occurs when valid and ready are both 1.
- hold  in  1  1 = issue no new instructions; in-flight work still drains.
- pipe_in_valid  out  1  drives the pipe's in_valid.
- pipe_instruction  out  32  drives the pipe's instruction.
- pipe_output_reg  out  15  drives the pipe's output_reg.
- pipe_out_valid, pipe_fail  in  1  pipe's out_valid and intruction_fail.
- pipe_out_1, pipe_out_2, pipe_out_3  in  32 each  pipe result words.
- rsp_valid  out  1  response strobe.
- rsp_id  out  1  requester that owns the response.
- rsp_fail  out  1  instruction failed.
- rsp_out_1, rsp_out_2, rsp_out_3  out  32 each  results.
- stall_cnt  out  16  count of hazard-stall cycles, saturating.
- err_orphan  out  1  sticky error flag.

Function
REQ-003 At most one grant per cycle; reqN_ready SHALL be combinational from the valids, the priority pointer, hold and the hazard check.
REQ-004 Arbitration SHALL be round-robin.
- 1-bit pointer selects the preferred requester.
- If only one requester is valid, it wins.
- After any grant, the pointer SHALL move to the requester that was not granted.
- With no grant, the pointer SHALL hold.
REQ-005 A granted instruction SHALL be registered into pipe_instruction / pipe_output_reg, with pipe_in_valid=1, at the next edge.
- In any cycle without a grant, pipe_in_valid SHALL be 0 and the data registers SHALL hold their values.
REQ-006 Destination of the issue register:
- opcode[31:26]=000000: [15:11].
- opcode=001000: [20:16].
- Any other opcode: no destination.
REQ-007 Hazard: while pipe_in_valid=1 and the issue register has a destination, a candidate whose [25:21] or [20:16] equals that destination SHALL NOT be granted that cycle.
- This stalls the candidate exactly one cycle, because the next cycle has pipe_in_valid=0.
- The comparison SHALL use both fields for every opcode.
REQ-008 When a hazard blocks the winning candidate, the other requester SHALL NOT be granted that cycle, and the pointer SHALL hold.
REQ-009 stall_cnt SHALL increment by 1 in each cycle where REQ-007 blocks a grant, and SHALL saturate at 16'hFFFF.
REQ-010 hold=1 SHALL force both readys to 0. Hold cycles SHALL NOT count as stalls.
REQ-011 Tag FIFO: the granted requester id SHALL be pushed on each grant.
- The head SHALL be popped on pipe_out_valid=1.
- Simultaneous push and pop SHALL both take effect, with the count unchanged.
- Full cannot occur because pipe latency is fixed; no full check is required beyond a wrap-around pointer.
REQ-012 One edge after pipe_out_valid=1 with the FIFO non-empty:
- rsp_valid SHALL be 1.
- rsp_id SHALL be the popped head.
- rsp_fail and rsp_out_1..3 SHALL be the registered pipe values.
- Otherwise rsp_valid SHALL be 0 and the data registers SHALL hold.
REQ-013 pipe_out_valid=1 with the FIFO empty SHALL NOT produce a response, and SHALL set err_orphan, which stays set until reset.
REQ-014 Latency from grant edge to rsp_valid SHALL be 6 cycles, given the pipe's 4-register latency: issue register, 4 pipe stages, response register.
REQ-015 Responses SHALL return in issue order.

Reset
REQ-016 While rst_n=0 at an edge, the following SHALL be cleared:
- pipe_in_valid, pipe_instruction, pipe_output_reg.
- rsp_valid, rsp_id, rsp_fail, rsp_out_1..3.
- stall_cnt, err_orphan.
- FIFO pointers and count; pointer set to req0.
REQ-017 reqN_ready SHALL be 0 while rst_n=0.
REQ-018 Reset mid-operation SHALL discard all in-flight tags.
- Pipe results arriving after reset are orphans (REQ-013).

Verification
REQ-019 Bench SHALL cover the following.
- Both requesters valid continuously with independent registers → grants alternate 0,1,0,1; responses return with rsp_id 0,1,0,1 six cycles after each grant; stall_cnt=0.
- req0 issues add rd=10001; the next instruction reads rs=10001 → one bubble (pipe_in_valid=0), stall_cnt=1, and the dependent result uses the updated register value.
- Hazard on the req1 candidate while req0 is also valid → neither granted that cycle; req1 granted the next cycle; pointer then prefers req0.
- hold=1 with 3 instructions in flight → no new grants; 3 responses still delivered; stall_cnt unchanged.
- pipe_out_valid forced high with nothing issued → rsp_valid stays 0; err_orphan=1 until rst_n=0.
- rst_n=0 for one cycle with 2 instructions in flight → all outputs 0; FIFO empty; the late pipe results set err_orphan and produce no response.
